spi_shift_engine: RTL

Mode-0 SPI shift engine that sits directly downstream of the clock divider. It consumes the divider's one-cycle tick and treats each tick as one SCLK half-period. It serialises a parallel word onto MOSI, MSB first, and deserialises MISO into a parallel word, using a valid/ready handshake on the host side. CS, SCLK and MOSI are all registered outputs.

---
 rtl/spi_shift_engine.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - mode-0 SPI shift engine driven by a divider tick
module spi_shift_engine #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_sclk,
  output logic             o_cs_n,
  output logic             o_mosi,
  input  logic             i_miso
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_tx_sr;
  logic [WIDTH-1:0] w_tx_sr_nxt;
  logic [WIDTH-1:0] r_rx_sr;
  logic [WIDTH-1:0] w_rx_sr_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic             r_sclk;
  logic             w_sclk_nxt;
  logic             r_cs_n;
  logic             w_cs_n_nxt;
  logic             r_mosi;
  logic             w_mosi_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;

  // Shifted copy of the transmit register; its MSB is the next bit to drive.
  logic [WIDTH-1:0] w_tx_shl;
  logic [WIDTH-1:0] w_rx_shl;

  assign w_tx_shl = r_tx_sr << 1;
  assign w_rx_shl = {r_rx_sr[WIDTH-2:0], i_miso};

  // State and datapath registers; reset drops CS/SCLK without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_sr   <= w_tx_sr_nxt;
      r_rx_sr   <= w_rx_sr_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sclk    <= w_sclk_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_mosi    <= w_mosi_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  // Next-state logic: every non-idle step waits for a tick; idle ignores ticks.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_sr_nxt   = r_tx_sr;
    w_rx_sr_nxt   = r_rx_sr;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sclk_nxt    = r_sclk;
    w_cs_n_nxt    = r_cs_n;
    w_mosi_nxt    = r_mosi;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_tx_sr_nxt   = i_data;
          w_mosi_nxt    = i_data[WIDTH-1];
          w_cs_n_nxt    = 1'b0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (i_tick) begin
          w_sclk_nxt  = 1'b1;
          w_rx_sr_nxt = w_rx_shl;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_tick) begin
          if (!r_sclk) begin
            w_sclk_nxt  = 1'b1;
            w_rx_sr_nxt = w_rx_shl;
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_bit_cnt == LAST_BIT) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
              w_tx_sr_nxt   = w_tx_shl;
              w_mosi_nxt    = w_tx_shl[WIDTH-1];
            end
          end
        end
      end
      S_HOLD: begin
        if (i_tick) begin
          w_cs_n_nxt  = 1'b1;
          w_data_nxt  = r_rx_sr;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (i_tick) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_busy  = (r_state != S_IDLE);
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_sclk  = r_sclk;
  assign o_cs_n  = r_cs_n;
  assign o_mosi  = r_mosi;

endmodule
